// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control slice.
// Stage metadata layout, PC-select encodings and RV32I opcodes.
package pipe_pkg;

    typedef struct packed {
        logic [4:0] addr1;
        logic [4:0] addr2;
        logic [4:0] waddr;
        logic [6:0] op;
    } stage_meta_t;

    localparam logic [6:0] BUBBLE_OP = 7'b000_0000;
    localparam stage_meta_t BUBBLE = '{
        addr1: 5'd0, addr2: 5'd0, waddr: 5'd0, op: BUBBLE_OP
    };

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_JAL   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;
    localparam logic [1:0] PC_BR    = 2'b11;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/instr_fields.sv
// Combinational register-field decoder for one instruction word.
// Fields the opcode does not use are zeroed so hazard compares stay clean.
module instr_fields
    import pipe_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] instr,
    output stage_meta_t meta
);

    // Slice the fields, then blank the ones this format lacks
    always_comb begin
        meta = BUBBLE;
        if (valid) begin
            meta.op    = instr[6:0];
            meta.addr1 = instr[19:15];
            meta.addr2 = instr[24:20];
            meta.waddr = instr[11:7];
            case (instr[6:0])
                OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                    meta.addr1 = 5'd0;
                    meta.addr2 = 5'd0;
                end
                OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                    meta.addr2 = 5'd0;
                end
                OPC_STORE, OPC_BRANCH: begin
                    meta.waddr = 5'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Applies hazard-unit stall/flush/redirect to the PC and stage metadata.
// Also drives datapath register strobes and the retired counter.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      F_INSTR,
    input  logic             F_VALID,
    input  logic             STALL,
    input  logic             FLUSH,
    input  logic [1:0]       PC_SEL,
    input  logic [31:0]      JAL_TGT,
    input  logic [31:0]      JALR_TGT,
    input  logic [31:0]      BR_TGT,
    output logic [31:0]      PC,
    output logic [4:0]       F_ADDR1,
    output logic [4:0]       F_ADDR2,
    output logic [4:0]       F_WADDR,
    output logic [6:0]       F_OP,
    output logic [4:0]       D_ADDR1,
    output logic [4:0]       D_ADDR2,
    output logic [4:0]       D_WADDR,
    output logic [6:0]       D_OP,
    output logic [4:0]       E_ADDR1,
    output logic [4:0]       E_ADDR2,
    output logic [4:0]       E_WADDR,
    output logic [6:0]       E_OP,
    output logic [4:0]       M_ADDR1,
    output logic [4:0]       M_ADDR2,
    output logic [4:0]       M_WADDR,
    output logic [6:0]       M_OP,
    output logic [4:0]       W_ADDR1,
    output logic [4:0]       W_ADDR2,
    output logic [4:0]       W_WADDR,
    output logic [6:0]       W_OP,
    output logic             PC_WE,
    output logic             FD_WE,
    output logic             FD_CLR,
    output logic             DE_CLR,
    output logic [CNT_W-1:0] RETIRED
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q;
    logic [31:0]      pc_next;
    stage_meta_t      f_meta;
    stage_meta_t      d_q;
    stage_meta_t      e_q;
    stage_meta_t      m_q;
    stage_meta_t      w_q;
    logic [CNT_W-1:0] ret_q;
    logic             pc_we;
    logic             fd_we;
    logic             fd_clr;
    logic             de_clr;

    instr_fields u_f_fields (
        .valid (F_VALID),
        .instr (F_INSTR),
        .meta  (f_meta)
    );

    // Strobes: reset > stall > flush > fetch bubble > normal advance
    always_comb begin
        pc_we  = 1'b0;
        fd_we  = 1'b0;
        fd_clr = 1'b0;
        de_clr = 1'b0;
        if (RST) begin
            fd_clr = 1'b1;
            de_clr = 1'b1;
        end else if (STALL) begin
            de_clr = 1'b1;
        end else if (FLUSH) begin
            pc_we  = 1'b1;
            fd_clr = 1'b1;
        end else if (!F_VALID) begin
            fd_clr = 1'b1;
        end else begin
            pc_we = 1'b1;
            fd_we = 1'b1;
        end
    end

    // Next PC: a flush always redirects to the JALR target
    always_comb begin
        pc_next = pc_q + 32'd4;
        if (FLUSH) begin
            pc_next = JALR_TGT;
        end else begin
            case (PC_SEL)
                PC_JAL:  pc_next = JAL_TGT;
                PC_JALR: pc_next = JALR_TGT;
                PC_BR:   pc_next = BR_TGT;
                default: pc_next = pc_q + 32'd4;
            endcase
        end
    end

    // PC, stage shift register and retired count
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q  <= RESET_VEC;
            d_q   <= BUBBLE;
            e_q   <= BUBBLE;
            m_q   <= BUBBLE;
            w_q   <= BUBBLE;
            ret_q <= '0;
        end else begin
            if (pc_we) begin
                pc_q <= pc_next;
            end
            if (fd_we) begin
                d_q <= f_meta;
            end else if (fd_clr) begin
                d_q <= BUBBLE;
            end
            e_q <= de_clr ? BUBBLE : d_q;
            m_q <= e_q;
            w_q <= m_q;
            if (m_q.op != BUBBLE_OP) begin
                ret_q <= ret_q + CNT_ONE;
            end
        end
    end

    assign PC      = pc_q;
    assign F_ADDR1 = f_meta.addr1;
    assign F_ADDR2 = f_meta.addr2;
    assign F_WADDR = f_meta.waddr;
    assign F_OP    = f_meta.op;
    assign D_ADDR1 = d_q.addr1;
    assign D_ADDR2 = d_q.addr2;
    assign D_WADDR = d_q.waddr;
    assign D_OP    = d_q.op;
    assign E_ADDR1 = e_q.addr1;
    assign E_ADDR2 = e_q.addr2;
    assign E_WADDR = e_q.waddr;
    assign E_OP    = e_q.op;
    assign M_ADDR1 = m_q.addr1;
    assign M_ADDR2 = m_q.addr2;
    assign M_WADDR = m_q.waddr;
    assign M_OP    = m_q.op;
    assign W_ADDR1 = w_q.addr1;
    assign W_ADDR2 = w_q.addr2;
    assign W_WADDR = w_q.waddr;
    assign W_OP    = w_q.op;
    assign PC_WE   = pc_we;
    assign FD_WE   = fd_we;
    assign FD_CLR  = fd_clr;
    assign DE_CLR  = de_clr;
    assign RETIRED = ret_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: per-cycle model compare plus directed literals.
// Model holds the pipe as a 4-slot array D,E,M,W of 22-bit field bundles.
module tb_pipe_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] F_INSTR;
    logic        F_VALID;
    logic        STALL;
    logic        FLUSH;
    logic [1:0]  PC_SEL;
    logic [31:0] JAL_TGT;
    logic [31:0] JALR_TGT;
    logic [31:0] BR_TGT;
    logic [31:0] PC;
    logic [4:0]  F_ADDR1, F_ADDR2, F_WADDR;
    logic [6:0]  F_OP;
    logic [4:0]  D_ADDR1, D_ADDR2, D_WADDR;
    logic [6:0]  D_OP;
    logic [4:0]  E_ADDR1, E_ADDR2, E_WADDR;
    logic [6:0]  E_OP;
    logic [4:0]  M_ADDR1, M_ADDR2, M_WADDR;
    logic [6:0]  M_OP;
    logic [4:0]  W_ADDR1, W_ADDR2, W_WADDR;
    logic [6:0]  W_OP;
    logic        PC_WE, FD_WE, FD_CLR, DE_CLR;
    logic [31:0] RETIRED;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADDI  = 32'h0010_0093;
    localparam logic [31:0] I_LOAD  = 32'h0000_A283;
    localparam logic [31:0] I_ADD   = 32'h0012_8333;
    localparam logic [31:0] I_JALR  = 32'h0001_00E7;
    localparam logic [31:0] I_JAL   = 32'h1234_50EF;
    localparam logic [31:0] I_STORE = 32'h0071_A223;

    pipe_ctrl dut (
        .CLK(CLK), .RST(RST), .F_INSTR(F_INSTR), .F_VALID(F_VALID),
        .STALL(STALL), .FLUSH(FLUSH), .PC_SEL(PC_SEL),
        .JAL_TGT(JAL_TGT), .JALR_TGT(JALR_TGT), .BR_TGT(BR_TGT),
        .PC(PC),
        .F_ADDR1(F_ADDR1), .F_ADDR2(F_ADDR2), .F_WADDR(F_WADDR), .F_OP(F_OP),
        .D_ADDR1(D_ADDR1), .D_ADDR2(D_ADDR2), .D_WADDR(D_WADDR), .D_OP(D_OP),
        .E_ADDR1(E_ADDR1), .E_ADDR2(E_ADDR2), .E_WADDR(E_WADDR), .E_OP(E_OP),
        .M_ADDR1(M_ADDR1), .M_ADDR2(M_ADDR2), .M_WADDR(M_WADDR), .M_OP(M_OP),
        .W_ADDR1(W_ADDR1), .W_ADDR2(W_ADDR2), .W_WADDR(W_WADDR), .W_OP(W_OP),
        .PC_WE(PC_WE), .FD_WE(FD_WE), .FD_CLR(FD_CLR), .DE_CLR(DE_CLR),
        .RETIRED(RETIRED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Field rule: {addr1,addr2,waddr,op}, unused fields zero, 0 if invalid
    function automatic logic [21:0] fields(input logic v, input logic [31:0] i);
        logic [4:0] a1, a2, wa;
        logic [6:0] op;
        if (!v) return 22'd0;
        op = i[6:0];
        a1 = i[19:15];
        a2 = i[24:20];
        wa = i[11:7];
        if (op == 7'h37 || op == 7'h17 || op == 7'h6F) begin
            a1 = 0;
            a2 = 0;
        end
        if (op == 7'h13 || op == 7'h03 || op == 7'h67) a2 = 0;
        if (op == 7'h23 || op == 7'h63) wa = 0;
        return {a1, a2, wa, op};
    endfunction

    logic [31:0] m_pc;
    logic [21:0] m_st [4];
    int unsigned m_ret;
    bit          m_ok = 0;

    // Model: advance the 4-slot pipe by the priority rules
    always @(posedge CLK) begin
        if (RST) begin
            m_pc = 32'h0;
            for (int k = 0; k < 4; k++) m_st[k] = 22'd0;
            m_ret = 0;
            m_ok = 1;
        end else if (m_ok) begin
            if (m_st[2][6:0] != 7'd0) m_ret = m_ret + 1;
            m_st[3] = m_st[2];
            m_st[2] = m_st[1];
            if (STALL) begin
                m_st[1] = 22'd0;
            end else begin
                m_st[1] = m_st[0];
                if (FLUSH) begin
                    m_pc = JALR_TGT;
                    m_st[0] = 22'd0;
                end else if (!F_VALID) begin
                    m_st[0] = 22'd0;
                end else begin
                    m_st[0] = fields(1'b1, F_INSTR);
                    case (PC_SEL)
                        2'd0: m_pc = m_pc + 32'd4;
                        2'd1: m_pc = JAL_TGT;
                        2'd2: m_pc = JALR_TGT;
                        default: m_pc = BR_TGT;
                    endcase
                end
            end
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge CLK) begin
        logic [3:0] s;
        if (m_ok) begin
            if (RST) s = 4'b0011;
            else if (STALL) s = 4'b0001;
            else if (FLUSH) s = 4'b1010;
            else if (!F_VALID) s = 4'b0010;
            else s = 4'b1100;
            chk("strobes", {28'd0, PC_WE, FD_WE, FD_CLR, DE_CLR}, {28'd0, s});
            chk("pc", PC, m_pc);
            chk("f", {10'd0, F_ADDR1, F_ADDR2, F_WADDR, F_OP},
                {10'd0, fields(F_VALID, F_INSTR)});
            chk("d", {10'd0, D_ADDR1, D_ADDR2, D_WADDR, D_OP}, {10'd0, m_st[0]});
            chk("e", {10'd0, E_ADDR1, E_ADDR2, E_WADDR, E_OP}, {10'd0, m_st[1]});
            chk("m", {10'd0, M_ADDR1, M_ADDR2, M_WADDR, M_OP}, {10'd0, m_st[2]});
            chk("w", {10'd0, W_ADDR1, W_ADDR2, W_WADDR, W_OP}, {10'd0, m_st[3]});
            chk("retired", RETIRED, m_ret);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1; F_VALID = 1; F_INSTR = I_ADDI; STALL = 0; FLUSH = 0;
        PC_SEL = 2'd0; JAL_TGT = 0; JALR_TGT = 0; BR_TGT = 0;
        tick();
        tick();
        chk("rst_fdclr", {31'd0, FD_CLR}, 32'd1);
        chk("rst_declr", {31'd0, DE_CLR}, 32'd1);
        chk("rst_pcwe", {31'd0, PC_WE}, 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_ret", RETIRED, 32'd0);
        RST = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) chk("pc_step", PC, 32'h4);
            if (i == 3) chk("w_pre", {25'd0, W_OP}, 32'h0);
            if (i == 4) begin
                chk("w_addi", {25'd0, W_OP}, 32'h13);
                chk("ret_one", RETIRED, 32'd1);
            end
        end
        F_INSTR = I_LOAD;
        tick();
        F_INSTR = I_ADD;
        tick();
        F_INSTR = I_ADDI;
        STALL = 1;
        tick();
        STALL = 0;
        chk("stall_pc", PC, 32'h20);
        chk("stall_dop", {25'd0, D_OP}, 32'h33);
        chk("stall_da1", {27'd0, D_ADDR1}, 32'd5);
        chk("stall_eop", {25'd0, E_OP}, 32'h0);
        chk("stall_mop", {25'd0, M_OP}, 32'h03);
        tick();
        chk("post_eop", {25'd0, E_OP}, 32'h33);
        chk("post_pc", PC, 32'h24);
        F_INSTR = I_JALR;
        tick();
        F_INSTR = I_ADDI;
        FLUSH = 1;
        JALR_TGT = 32'h100;
        #1;
        chk("flush_fdclr", {31'd0, FD_CLR}, 32'd1);
        tick();
        FLUSH = 0;
        chk("flush_pc", PC, 32'h100);
        chk("flush_dop", {25'd0, D_OP}, 32'h0);
        chk("flush_eop", {25'd0, E_OP}, 32'h67);
        F_INSTR = I_JAL;
        PC_SEL = 2'd1;
        JAL_TGT = 32'h40;
        tick();
        PC_SEL = 2'd0;
        chk("jal_pc", PC, 32'h40);
        chk("jal_dop", {25'd0, D_OP}, 32'h6F);
        chk("jal_da12", {22'd0, D_ADDR1, D_ADDR2}, 32'd0);
        chk("jal_dwa", {27'd0, D_WADDR}, 32'd1);
        F_INSTR = I_ADDI;
        PC_SEL = 2'd3;
        BR_TGT = 32'h20;
        tick();
        PC_SEL = 2'd0;
        chk("br_pc", PC, 32'h20);
        STALL = 1;
        FLUSH = 1;
        JALR_TGT = 32'h300;
        tick();
        STALL = 0;
        FLUSH = 0;
        chk("sf_pc", PC, 32'h20);
        chk("sf_dop", {25'd0, D_OP}, 32'h13);
        chk("sf_dwa", {27'd0, D_WADDR}, 32'd1);
        F_VALID = 0;
        #1;
        chk("nv_fop", {25'd0, F_OP}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nv_pc", PC, 32'h20);
            chk("nv_dop", {25'd0, D_OP}, 32'h0);
        end
        F_VALID = 1;
        PC_SEL = 2'd3;
        BR_TGT = 32'hFFFF_FFFC;
        tick();
        chk("top_pc", PC, 32'hFFFF_FFFC);
        PC_SEL = 2'd0;
        F_INSTR = I_STORE;
        #1;
        chk("st_fwa", {27'd0, F_WADDR}, 32'd0);
        chk("st_fa2", {27'd0, F_ADDR2}, 32'd7);
        chk("st_fop", {25'd0, F_OP}, 32'h23);
        tick();
        chk("wrap_pc", PC, 32'h0);
        chk("st_dop", {25'd0, D_OP}, 32'h23);
        F_INSTR = I_ADDI;
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
